// File: rtl/ppm_pkg.sv
// Shared timing constants, state/order encodings and small offset helpers
// for the 4-PPM receive path.
package ppm_pkg;

    localparam logic [7:0] SYM_LEN   = 8'd128;
    localparam logic [7:0] PULSE_LEN = 8'd16;
    localparam logic [7:0] SLOT_LEN  = 8'd32;
    localparam logic [7:0] SOF_GAP   = 8'd80;
    localparam logic [7:0] EOF_OFS   = 8'd31;
    localparam logic [7:0] TOL       = 8'd4;
    localparam logic [4:0] MAX_BYTES = 5'd16;

    typedef enum logic [1:0] {
        ORD_IDLE,
        ORD_SOF,
        ORD_DATA,
        ORD_EOF
    } order_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF1,
        ST_SOF_GAP,
        ST_SOF2,
        ST_ALIGN,
        ST_DATA,
        ST_EOF_CHK
    } state_e;

    function automatic logic near(input logic [7:0] v, input logic [7:0] c);
        logic [7:0] d;
        d = (v >= c) ? v - c : c - v;
        return d <= TOL;
    endfunction

    function automatic logic [7:0] slot_ofs(input logic [1:0] k);
        return PULSE_LEN + SLOT_LEN * {6'd0, k};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ppm_rx_edge.sv
// Receiver line front end: 2-FF synchronizer, edge detect and low-pulse
// width measurement.
module ppm_rx_edge
    import ppm_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       fall_o,
    output logic       rise_o,
    output logic       width_ok_o,
    output logic [7:0] width_o
);

    logic       sync1_q, sync2_q, prev_q;
    logic [7:0] width_q, width_d;

    assign fall_o = prev_q & ~sync2_q;
    assign rise_o = ~prev_q & sync2_q;

    // width_q equals the number of low cycles by the time the rise is seen
    always_comb begin
        width_d = width_q;
        if (fall_o)
            width_d = 8'd1;
        else if (!sync2_q)
            width_d = sat_inc(width_q);
    end

    assign width_ok_o = rise_o & near(width_q, PULSE_LEN);
    assign width_o    = width_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            width_q <= '0;
        end else begin
            sync1_q <= rx_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            width_q <= width_d;
        end
    end

endmodule

// File: rtl/ppm_decoder.sv
// 4-PPM frame decoder: SOF detection, symbol timebase recovery, byte
// reassembly (LSB pair first), EOF and framing-error reporting.
module ppm_decoder
    import ppm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_start,
    output logic       frame_done,
    output logic       frame_err,
    output logic [4:0] byte_count,
    output logic       busy
);

    logic       fall, rise, width_ok;
    logic [7:0] width;

    ppm_rx_edge u_edge (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_i       (rx_in),
        .fall_o     (fall),
        .rise_o     (rise),
        .width_ok_o (width_ok),
        .width_o    (width)
    );

    state_e     state_q, state_d;
    logic [7:0] fc_q, fc_d, wc_q, wc_d;
    logic [1:0] si_q, si_d, sym_q, sym_d;
    logic       seen_q, seen_d;
    logic [7:0] shift_q, shift_d;
    logic [4:0] bcnt_q, bcnt_d;
    logic       busy_q, busy_d;
    logic [7:0] rdata_q, rdata_d;
    logic       rvalid_q, rvalid_d, fstart_q, fstart_d;
    logic       fdone_q, fdone_d, ferr_q, ferr_d;
    logic       err, hit;
    logic [1:0] hit_sym;

    always_comb begin
        state_d  = state_q;
        fc_d     = sat_inc(fc_q);
        wc_d     = sat_inc(wc_q);
        si_d     = si_q;
        sym_d    = sym_q;
        seen_d   = seen_q;
        shift_d  = shift_q;
        bcnt_d   = bcnt_q;
        busy_d   = busy_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        fstart_d = 1'b0;
        fdone_d  = 1'b0;
        ferr_d   = 1'b0;
        err      = 1'b0;
        hit      = 1'b0;
        hit_sym  = '0;

        for (int unsigned k = 0; k < 4; k++) begin
            if (near(wc_q, slot_ofs(2'(k)))) begin
                hit     = 1'b1;
                hit_sym = 2'(k);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    fc_d    = 8'd1;
                    state_d = ST_SOF1;
                end
            end
            ST_SOF1: begin
                if (rise)
                    state_d = width_ok ? ST_SOF_GAP : ST_IDLE;
                else if (fc_q > SOF_GAP + TOL)
                    state_d = ST_IDLE;
            end
            ST_SOF_GAP: begin
                if (fall)
                    state_d = near(fc_q, SOF_GAP) ? ST_SOF2 : ST_IDLE;
                else if (fc_q > SOF_GAP + TOL)
                    state_d = ST_IDLE;
            end
            ST_SOF2: begin
                if (rise) begin
                    if (width_ok) begin
                        fstart_d = 1'b1;
                        busy_d   = 1'b1;
                        bcnt_d   = '0;
                        si_d     = '0;
                        seen_d   = 1'b0;
                        shift_d  = '0;
                        state_d  = ST_ALIGN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (fc_q >= SYM_LEN - 8'd1) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ALIGN: begin
                if (rise && !width_ok)
                    err = 1'b1;
                else if (fc_q == SYM_LEN - 8'd1) begin
                    wc_d    = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                wc_d = (wc_q == SYM_LEN - 8'd1) ? '0 : wc_q + 8'd1;
                if (rise && !width_ok)
                    err = 1'b1;
                else if (fall) begin
                    if (seen_q)
                        err = 1'b1;
                    else if (hit) begin
                        seen_d = 1'b1;
                        sym_d  = hit_sym;
                    end else if (near(wc_q, EOF_OFS) && si_q == 2'd0)
                        state_d = ST_EOF_CHK;
                    else
                        err = 1'b1;
                end
                // window close: commit the symbol, emit on the 4th pair
                if (!err && state_d == ST_DATA && wc_q == SYM_LEN - 8'd1) begin
                    if (!seen_q)
                        err = 1'b1;
                    else begin
                        shift_d[{si_q, 1'b0} +: 2] = sym_q;
                        seen_d = 1'b0;
                        si_d   = si_q + 2'd1;
                        if (si_q == 2'd3) begin
                            if (bcnt_q == MAX_BYTES)
                                err = 1'b1;
                            else begin
                                rvalid_d = 1'b1;
                                rdata_d  = shift_d;
                                bcnt_d   = bcnt_q + 5'd1;
                            end
                        end
                    end
                end
            end
            ST_EOF_CHK: begin
                if (rise) begin
                    if (width_ok) begin
                        fdone_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        err = 1'b1;
                    end
                end else if (width > PULSE_LEN + TOL) begin
                    err = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (err) begin
            state_d  = ST_IDLE;
            busy_d   = 1'b0;
            ferr_d   = 1'b1;
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            fc_q     <= '1;
            wc_q     <= '1;
            si_q     <= '0;
            sym_q    <= '0;
            seen_q   <= 1'b0;
            shift_q  <= '0;
            bcnt_q   <= '0;
            busy_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            fstart_q <= 1'b0;
            fdone_q  <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fc_q     <= fc_d;
            wc_q     <= wc_d;
            si_q     <= si_d;
            sym_q    <= sym_d;
            seen_q   <= seen_d;
            shift_q  <= shift_d;
            bcnt_q   <= bcnt_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            fstart_q <= fstart_d;
            fdone_q  <= fdone_d;
            ferr_q   <= ferr_d;
        end
    end

    assign rx_data     = rdata_q;
    assign rx_valid    = rvalid_q;
    assign frame_start = fstart_q;
    assign frame_done  = fdone_q;
    assign frame_err   = ferr_q;
    assign byte_count  = bcnt_q;
    assign busy        = busy_q;

endmodule
